// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and the byte-lane merge helper for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // One requester's transaction, bundled so the granted port can be selected in one mux.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } port_req_t;

  // Takes each byte lane from new_word where be is set, otherwise keeps old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  function automatic logic is_partial_write(input port_req_t r);
    return r.we && (r.be != BE_FULL) && (r.be != BE_NONE);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: fixed priority to input 0, or round-robin driven by the last granted input.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1 means input 1 won most recently, so input 0 takes the next tie.
  logic last_gnt;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (FIXED_PRIO || last_gnt) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt[1]) begin
      last_gnt <= 1'b1;
    end else if (gnt[0]) begin
      last_gnt <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-wide single-port data memory between the LSU (port 0) and DMA (port 1),
// sequencing sub-word writes as a two-cycle read-modify-write.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,

  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e  state;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        grant_en;
  port_req_t   p0_bus;
  port_req_t   p1_bus;
  port_req_t   sel;

  assign req      = {p1_req, p0_req};
  // Grants are combinational so the memory access lands in the same cycle; reset blocks them.
  assign grant_en = rst_n && (state == IDLE);

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (grant_en),
    .gnt   (gnt)
  );

  assign p0_gnt = gnt[PORT0];
  assign p1_gnt = gnt[PORT1];

  assign p0_bus = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, be: p0_be};
  assign p1_bus = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, be: p1_be};
  assign sel    = gnt[PORT1] ? p1_bus : p0_bus;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == RMW_WR) begin
      // A reset landing on the write half abandons the merged word.
      if (rst_n) begin
        mem_write = 1'b1;
        mem_addr  = rmw_addr;
        mem_wdata = rmw_data;
      end
    end else if (gnt != 2'b00) begin
      if (!sel.we) begin
        mem_read = 1'b1;
        mem_addr = sel.addr;
      end else if (sel.be == BE_FULL) begin
        mem_write = 1'b1;
        mem_addr  = sel.addr;
        mem_wdata = sel.wdata;
      end else if (sel.be != BE_NONE) begin
        mem_read = 1'b1;
        mem_addr = sel.addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rmw_addr  <= '0;
      rmw_data  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt[PORT0] && !p0_we;
      p1_rvalid <= gnt[PORT1] && !p1_we;
      if (gnt[PORT0] && !p0_we) p0_rdata <= mem_rdata;
      if (gnt[PORT1] && !p1_we) p1_rdata <= mem_rdata;

      case (state)
        IDLE: begin
          if ((gnt != 2'b00) && is_partial_write(sel)) begin
            rmw_addr <= sel.addr;
            rmw_data <= byte_merge(mem_rdata, sel.wdata, sel.be);
            state    <= RMW_WR;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural memory, a reference word model updated in
// grant order, and per-port queues of expected read data popped on each rvalid.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;

  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [3:0]  p0_be;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_be;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Fixed-priority instance, used only for grant ordering.
  logic        f0_req, f0_we, f0_gnt, f0_rvalid;
  logic [31:0] f0_addr, f0_wdata, f0_rdata;
  logic [3:0]  f0_be;
  logic        f1_req, f1_we, f1_gnt, f1_rvalid;
  logic [31:0] f1_addr, f1_wdata, f1_rdata;
  logic [3:0]  f1_be;
  logic        fm_read, fm_write;
  logic [31:0] fm_addr, fm_wdata, fm_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q0  [$];
  logic [31:0] exp_q1  [$];
  logic        mem_load;
  logic        mon_en;
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(f0_req), .p0_we(f0_we), .p0_addr(f0_addr), .p0_wdata(f0_wdata), .p0_be(f0_be),
    .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata),
    .p1_req(f1_req), .p1_we(f1_we), .p1_addr(f1_addr), .p1_wdata(f1_wdata), .p1_be(f1_be),
    .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid), .p1_rdata(f1_rdata),
    .mem_read(fm_read), .mem_write(fm_write), .mem_addr(fm_addr),
    .mem_wdata(fm_wdata), .mem_rdata(fm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'hDEADBEEF;
      8:       return 32'h11223344;
      12:      return 32'hCAFEF00D;
      16:      return 32'h01234567;
      default: return 32'h5A000000 + 32'(i);
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old_w, new_w, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & m) | (old_w & ~m);
  endfunction

  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;
  assign fm_rdata  = 32'h0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Applies a granted transaction to the reference model in grant order.
  task automatic apply_grant(input bit p, input logic we, input logic [31:0] a, d,
                             input logic [3:0] be);
    if (!we) begin
      if (p) exp_q1.push_back(ref_mem[a[7:2]]);
      else   exp_q0.push_back(ref_mem[a[7:2]]);
    end else begin
      ref_mem[a[7:2]] = ref_merge(ref_mem[a[7:2]], d, be);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (mem_load) begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      end else if (mon_en) begin
        if (p0_gnt && p1_gnt) check("dual_gnt", 32'd1, 32'd0);
        if (p0_rvalid) begin
          if (exp_q0.size() == 0) check("p0_spurious_rvalid", 32'd1, 32'd0);
          else                    check("p0_rdata_sb", p0_rdata, exp_q0.pop_front());
        end
        if (p1_rvalid) begin
          if (exp_q1.size() == 0) check("p1_spurious_rvalid", 32'd1, 32'd0);
          else                    check("p1_rdata_sb", p1_rdata, exp_q1.pop_front());
        end
        if (p0_gnt) apply_grant(1'b0, p0_we, p0_addr, p0_wdata, p0_be);
        if (p1_gnt) apply_grant(1'b1, p1_we, p1_addr, p1_wdata, p1_be);
      end
    end
  endtask

  // Raises a request, waits (bounded) for its grant, then drops it right after the grant edge.
  task automatic issue(input bit p, input logic we, input logic [31:0] a, d, input logic [3:0] be);
    logic got;
    got = 1'b0;
    if (p) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be; end
    else   begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = p ? p1_gnt : p0_gnt;
    end
    check(p ? "p1_gnt_seen" : "p0_gnt_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (p) p1_req = 1'b0;
    else   p0_req = 1'b0;
  endtask

  task automatic wait_rvalid(input bit p);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = p ? p1_rvalid : p0_rvalid;
    end
    check(p ? "p1_rvalid_seen" : "p0_rvalid_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [1:0] g;
    rst_n = 1'b0; mem_load = 1'b1; mon_en = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = '0; p0_be = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0;    p1_wdata = '0; p1_be = '0;
    f0_req = 1'b0; f0_we = 1'b0; f0_addr = 32'h4; f0_wdata = '0; f0_be = '0;
    f1_req = 1'b0; f1_we = 1'b0; f1_addr = 32'h8; f1_wdata = '0; f1_be = '0;
    fork monitor_loop(); join_none

    // Reset holds everything quiet even with a request pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check("rst_p0_rdata", p0_rdata, 32'h0);
    end

    // Test 1: read word 4, grant at T and rvalid at T+1.
    @(posedge clk); #1;
    mem_load = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("t1_gnt", 32'(p0_gnt), 32'd1);
    check("t1_mem_read", 32'(mem_read), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_rvalid_early", 32'(p0_rvalid), 32'd0);
    @(posedge clk); #1; p0_req = 1'b0;
    @(negedge clk);
    check("t1_rvalid", 32'(p0_rvalid), 32'd1);
    check("t1_rdata", p0_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_rvalid_pulse", 32'(p0_rvalid), 32'd0);

    // Test 2: both ports hammer full-word writes; round-robin alternates, fixed priority starves p1.
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h50; p0_wdata = 32'hA0000000; p0_be = 4'hF;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'hA0; p1_wdata = 32'hB0000000; p1_be = 4'hF;
    f0_req = 1'b1; f1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = {p1_gnt, p0_gnt};
      check("t2_rr_gnt", 32'(g), (i % 2 == 0) ? 32'd2 : 32'd1);
      check("t2_fp_gnt", 32'({f1_gnt, f0_gnt}), 32'd1);
      @(posedge clk); #1;
      if (g[0]) begin p0_addr = p0_addr + 32'd4; p0_wdata = p0_wdata + 32'd1; end
      if (g[1]) begin p1_addr = p1_addr + 32'd4; p1_wdata = p1_wdata + 32'd1; end
    end
    p0_req = 1'b0; p1_req = 1'b0; f0_req = 1'b0;
    @(negedge clk);
    check("t2_fp_p1_alone", 32'({f1_gnt, f0_gnt}), 32'd2);
    @(posedge clk); #1; f1_req = 1'b0;

    // Test 3: partial write to word 8 runs as RMW; p0 waits through the write half.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hAABBCCDD; p1_be = 4'b0101;
    @(negedge clk);
    check("t3_gnt", 32'(p1_gnt), 32'd1);
    check("t3_rd_phase_read", 32'(mem_read), 32'd1);
    check("t3_rd_phase_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    p1_req = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20; p0_be = 4'h0;
    @(negedge clk);
    check("t3_wr_phase_write", 32'(mem_write), 32'd1);
    check("t3_wr_phase_read", 32'(mem_read), 32'd0);
    check("t3_wr_phase_data", mem_wdata, 32'h11BB33DD);
    check("t3_wr_phase_addr", mem_addr, 32'h20);
    check("t3_p0_blocked", 32'(p0_gnt), 32'd0);
    @(negedge clk);
    check("t3_p0_gnt_after", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1; p0_req = 1'b0;
    @(negedge clk);
    check("t3_rvalid", 32'(p0_rvalid), 32'd1);
    check("t3_readback", p0_rdata, 32'h11BB33DD);

    // Test 4: empty byte mask is granted but never touches memory.
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h30; p0_wdata = 32'hFFFFFFFF; p0_be = 4'h0;
    @(negedge clk);
    check("t4_gnt", 32'(p0_gnt), 32'd1);
    check("t4_no_access", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1; p0_req = 1'b0;
    @(negedge clk);
    check("t4_no_access_next", 32'({mem_read, mem_write}), 32'd0);
    check("t4_no_rvalid", 32'(p0_rvalid), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h30, 32'h0, 4'h0);
    wait_rvalid(1'b0);
    check("t4_readback", p0_rdata, 32'hCAFEF00D);

    // Test 5: reset on the write half of an RMW drops the write.
    @(posedge clk); #1;
    mon_en = 1'b0;
    issue(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0011);
    rst_n = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h40; p1_be = 4'h0;
    @(negedge clk);
    check("t5_no_write", 32'(mem_write), 32'd0);
    check("t5_no_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
    check("t5_no_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    check("t5_idle_gnt", 32'(p1_gnt), 32'd1);
    @(posedge clk); #1; p1_req = 1'b0;
    @(negedge clk);
    check("t5_rvalid", 32'(p1_rvalid), 32'd1);
    check("t5_word_kept", p1_rdata, 32'h01234567);
    check("t5_mem_word", mem[16], 32'h01234567);

    // Test 6: write then read of the same word, low address bits ignored on the read.
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 32'h20, 32'h00000005, 4'hF);
    issue(1'b1, 1'b0, 32'h23, 32'h0, 4'h0);
    wait_rvalid(1'b1);
    check("t6_readback", p1_rdata, 32'h00000005);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
    check("sb_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
